// File: rtl/cpu_pkg.sv
// Shared widths, opcode/ALU enums and instruction field positions
// for the small teaching CPU front end.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int NREGS  = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'd0,
    OPC_SUB  = 4'd1,
    OPC_AND  = 4'd2,
    OPC_SLL  = 4'd3,
    OPC_ADDI = 4'd4,
    OPC_LW   = 4'd5
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_SLL  = 3'd3,
    ALU_ADDI = 3'd4,
    ALU_LW   = 3'd5
  } alu_op_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'(OPC_LW);
  endfunction

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= 4'(OPC_AND);
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: three combinational read ports, one synchronous write
// port; R0 always reads zero and ignores writes.
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
  assign rd_data = (rd_addr == '0) ? '0 : regs_q[rd_addr];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, operand read, scoreboard interlock and a
// single-entry output register towards the ALU, plus status counters.
module decode_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_op,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [7:0]        out_imm8,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err_illegal,
  output logic              err_wb,
  output logic [15:0]       issued_cnt
);

  logic [3:0]        op_f;
  logic [REG_AW-1:0] rd_f, rs_f, rt_f;
  logic [7:0]        imm_f;
  logic [DATA_W-1:0] rs_data, rt_data, rd_data;
  logic              legal, rtype, hazard, accept, issue;

  logic              out_valid_q, out_valid_d;
  alu_op_t           out_op_q, out_op_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [7:0]        out_imm8_q, out_imm8_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              err_illegal_q, err_illegal_d, err_wb_q, err_wb_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;

  assign op_f  = in_instr[OP_MSB:OP_LSB];
  assign rd_f  = in_instr[RD_MSB:RD_LSB];
  assign rs_f  = in_instr[RS_MSB:RS_LSB];
  assign rt_f  = in_instr[RT_MSB:RT_LSB];
  assign imm_f = in_instr[IMM_MSB:IMM_LSB];

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs_f),
    .rt_addr (rt_f),
    .rd_addr (rd_f),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .rd_data (rd_data),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // Illegal opcodes read no registers, so they never stall
  always_comb begin
    legal  = is_legal(op_f);
    rtype  = is_rtype(op_f);
    hazard = 1'b0;
    if (legal) begin
      if (rtype) begin
        hazard = pending_q[rs_f] | pending_q[rt_f] | pending_q[rd_f];
      end else begin
        hazard = pending_q[rd_f];
      end
    end
  end

  assign in_ready = rst_n & (!out_valid_q | out_ready) & !hazard;
  assign accept   = in_valid & in_ready;
  assign issue    = accept & legal;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_rd_d      = out_rd_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_imm8_d    = out_imm8_q;
    pending_d     = pending_q;
    err_illegal_d = err_illegal_q;
    err_wb_d      = err_wb_q;
    issued_cnt_d  = issued_cnt_q;

    if (issue) begin
      out_valid_d  = 1'b1;
      out_op_d     = alu_op_t'(op_f[2:0]);
      out_rd_d     = rd_f;
      out_imm8_d   = imm_f;
      out_a_d      = rtype ? rs_data : rd_data;
      issued_cnt_d = issued_cnt_q + 16'd1;
      if (rtype) begin
        out_b_d = rt_data;
      end else if (op_f == 4'(OPC_SLL)) begin
        out_b_d = {8'h00, imm_f};
      end else begin
        out_b_d = {{8{imm_f[7]}}, imm_f};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && !legal) begin
      err_illegal_d = 1'b1;
    end

    // Clear first so a same-cycle issue to the same register keeps it pending
    if (wb_en) begin
      if (!pending_q[wb_addr]) begin
        err_wb_d = 1'b1;
      end
      pending_d[wb_addr] = 1'b0;
    end
    if (issue && (rd_f != '0)) begin
      pending_d[rd_f] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= ALU_ADD;
      out_rd_q      <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_imm8_q    <= '0;
      pending_q     <= '0;
      err_illegal_q <= 1'b0;
      err_wb_q      <= 1'b0;
      issued_cnt_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_rd_q      <= out_rd_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_imm8_q    <= out_imm8_d;
      pending_q     <= pending_d;
      err_illegal_q <= err_illegal_d;
      err_wb_q      <= err_wb_d;
      issued_cnt_q  <= issued_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_rd      = out_rd_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_imm8    = out_imm8_q;
  assign err_illegal = err_illegal_q;
  assign err_wb      = err_wb_q;
  assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic, all
// compared cycle by cycle against an instruction-level reference model.
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [15:0] in_instr, out_a, out_b, wb_data, issued_cnt;
  logic [2:0]  out_op;
  logic [3:0]  out_rd, wb_addr;
  logic [7:0]  out_imm8;
  logic        err_illegal, err_wb;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_regs [16];
  logic        m_pending [16];
  logic        m_valid, m_err_ill, m_err_wb;
  logic [2:0]  m_op;
  logic [3:0]  m_rd;
  logic [15:0] m_a, m_b, m_cnt;
  logic [7:0]  m_imm;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_imm8    (out_imm8),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err_illegal (err_illegal),
    .err_wb      (err_wb),
    .issued_cnt  (issued_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [15:0] instr, input logic ordy,
                               input logic wbe, input logic [3:0] wba, input logic [15:0] wbd);
    in_valid  = iv;
    in_instr  = instr;
    out_ready = ordy;
    wb_en     = wbe;
    wb_addr   = wba;
    wb_data   = wbd;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) begin
      m_regs[i]    = '0;
      m_pending[i] = 1'b0;
    end
    m_valid = 0; m_err_ill = 0; m_err_wb = 0;
    m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_imm = '0; m_cnt = '0;
  endtask

  // Every register an instruction reads or writes must be free to issue
  function automatic logic model_hazard(input logic [15:0] instr);
    logic [3:0] touched [$];
    int op;
    op = int'(instr[15:12]);
    if (op > 5) return 1'b0;
    touched.push_back(instr[11:8]);
    if (op <= 2) begin
      touched.push_back(instr[7:4]);
      touched.push_back(instr[3:0]);
    end
    foreach (touched[i]) if (m_pending[touched[i]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready();
    return rst_n && (!m_valid || out_ready) && !model_hazard(in_instr);
  endfunction

  task automatic modelEdge();
    logic       fire_in, fire_out;
    int         op;
    logic [3:0] rd, rs, rt;
    logic [7:0] imm;
    fire_in  = in_valid && exp_ready();
    fire_out = m_valid && out_ready;
    op  = int'(in_instr[15:12]);
    rd  = in_instr[11:8];
    rs  = in_instr[7:4];
    rt  = in_instr[3:0];
    imm = in_instr[7:0];
    if (fire_in && op <= 5) begin
      m_valid = 1'b1;
      m_op    = 3'(op);
      m_rd    = rd;
      m_imm   = imm;
      m_a     = (op <= 2) ? m_regs[rs] : m_regs[rd];
      if (op <= 2)      m_b = m_regs[rt];
      else if (op == 3) m_b = {8'h00, imm};
      else              m_b = {{8{imm[7]}}, imm};
      m_cnt++;
    end else if (fire_out) begin
      m_valid = 1'b0;
    end
    if (fire_in && op > 5) m_err_ill = 1'b1;
    if (wb_en) begin
      if (!m_pending[wb_addr]) m_err_wb = 1'b1;
      if (wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_pending[wb_addr] = 1'b0;
    end
    if (fire_in && op <= 5 && rd != 0) m_pending[rd] = 1'b1;
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".in_ready"},    in_ready,    exp_ready());
    checkOutput({ctx, ".out_valid"},   out_valid,   m_valid);
    checkOutput({ctx, ".out_op"},      out_op,      m_op);
    checkOutput({ctx, ".out_rd"},      out_rd,      m_rd);
    checkOutput({ctx, ".out_a"},       out_a,       m_a);
    checkOutput({ctx, ".out_b"},       out_b,       m_b);
    checkOutput({ctx, ".out_imm8"},    out_imm8,    m_imm);
    checkOutput({ctx, ".err_illegal"}, err_illegal, m_err_ill);
    checkOutput({ctx, ".err_wb"},      err_wb,      m_err_wb);
    checkOutput({ctx, ".issued_cnt"},  issued_cnt,  m_cnt);
  endtask

  task automatic step(input logic do_check, input string ctx);
    #1;
    if (do_check) checkAll(ctx);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] cnt_before;
    logic [15:0] instr;
    logic [3:0]  wa;
    int          guard;

    resetModel();
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    #1;
    checkAll("reset");
    checkOutput("reset.in_ready_low", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback to a register nobody is waiting on
    applyStimulus(0, 16'h0000, 1, 1, 4'd7, 16'h00AB);
    step(1, "wb_r7");
    checkOutput("wb_r7.err_wb", err_wb, 1);
    applyStimulus(1, 16'h0470, 1, 0, 0, 0);
    step(1, "add_r4_r7");
    checkOutput("add_r4_r7.out_a", out_a, 16'h00AB);

    // ADDI with sign-extended immediate, then dependent SUB stalls
    applyStimulus(0, 16'h0000, 1, 1, 4'd3, 16'h0005);
    step(1, "wb_r3");
    applyStimulus(1, 16'h43FF, 1, 0, 0, 0);
    step(1, "addi");
    checkOutput("addi.out_valid", out_valid, 1);
    checkOutput("addi.out_op", out_op, 3'd4);
    checkOutput("addi.out_a", out_a, 16'h0005);
    checkOutput("addi.out_b", out_b, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 16'h1133, 1, 0, 0, 0);
      #1 checkOutput("sub_stall.in_ready", in_ready, 0);
      step(1, "sub_stall");
    end
    applyStimulus(1, 16'h1133, 1, 1, 4'd3, 16'h1234);
    #1 checkOutput("sub_wb_edge.in_ready", in_ready, 0);
    step(1, "sub_wb_edge");
    applyStimulus(1, 16'h1133, 1, 0, 0, 0);
    #1 checkOutput("sub_after_wb.in_ready", in_ready, 1);
    step(1, "sub_issue");
    checkOutput("sub.out_op", out_op, 3'd1);
    checkOutput("sub.out_a", out_a, 16'h1234);
    checkOutput("sub.out_b", out_b, 16'h1234);

    // Downstream backpressure holds the output register
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 16'h0200, 0, 0, 0, 0);
      #1;
      checkOutput("hold.in_ready", in_ready, 0);
      checkOutput("hold.out_valid", out_valid, 1);
      checkOutput("hold.out_rd", out_rd, 4'd1);
      checkOutput("hold.out_a", out_a, 16'h1234);
      step(1, "hold");
    end
    applyStimulus(1, 16'h0200, 1, 0, 0, 0);
    #1 checkOutput("release.in_ready", in_ready, 1);
    step(1, "release");
    checkOutput("release.out_rd", out_rd, 4'd2);

    // Issue and writeback of the same register in one cycle: stays pending
    applyStimulus(1, 16'h4501, 1, 1, 4'd5, 16'h0077);
    step(1, "set_wins");
    checkOutput("set_wins.out_a", out_a, 16'h0000);
    applyStimulus(1, 16'h0650, 1, 0, 0, 0);
    #1 checkOutput("set_wins.stall", in_ready, 0);
    step(1, "set_wins_stall");
    applyStimulus(1, 16'h0650, 1, 1, 4'd5, 16'h0099);
    step(1, "set_wins_wb");
    applyStimulus(1, 16'h0650, 1, 0, 0, 0);
    step(1, "set_wins_issue");
    checkOutput("set_wins_issue.out_a", out_a, 16'h0099);

    // Illegal opcode is swallowed
    cnt_before = m_cnt;
    applyStimulus(1, 16'h9000, 1, 0, 0, 0);
    step(1, "illegal");
    checkOutput("illegal.out_valid", out_valid, 0);
    checkOutput("illegal.err_illegal", err_illegal, 1);
    checkOutput("illegal.issued_cnt", issued_cnt, cnt_before);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      instr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
      wa = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        for (int k = 0; k < 8; k++) if (m_pending[k]) wa = 4'(k);
      applyStimulus($urandom_range(0, 4) != 0, instr, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, wa, 16'($urandom));
      step(1, "random");
    end

    // Run the issue counter up to its wrap point
    guard = 0;
    applyStimulus(1, 16'h0000, 1, 0, 0, 0);
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(0, "count");
      guard++;
    end
    checkAll("count_top");
    checkOutput("count_top.issued_cnt", issued_cnt, 16'hFFFF);
    step(0, "count_wrap");
    checkOutput("count_wrap.issued_cnt", issued_cnt, 16'h0000);

    // Reset in the middle of a stalled handshake
    for (int k = 1; k < 8; k++) begin
      applyStimulus(0, 16'h0000, 1, 1, 4'(k), 16'(16'h1000 + k));
      step(1, "refill");
    end
    applyStimulus(1, 16'h0123, 1, 0, 0, 0);
    step(1, "pre_rst_add");
    applyStimulus(1, 16'h40FF, 1, 0, 0, 0);
    step(1, "pre_rst_addi");
    applyStimulus(0, 16'h0000, 0, 0, 0, 0);
    step(1, "pre_rst_hold");
    checkOutput("pre_rst.out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    resetModel();
    #1;
    checkAll("mid_reset");
    checkOutput("mid_reset.out_valid", out_valid, 0);
    checkOutput("mid_reset.out_b", out_b, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 16'h0112, 1, 0, 0, 0);
    #1 checkOutput("post_rst.in_ready", in_ready, 1);
    step(1, "post_rst_add");
    checkOutput("post_rst.out_a", out_a, 16'h0000);
    checkOutput("post_rst.out_b", out_b, 16'h0000);
    for (int k = 3; k < 16; k++) begin
      applyStimulus(1, {8'h00, 4'(k), 4'(k)}, 1, 0, 0, 0);
      step(1, "post_rst_read");
    end
    step(1, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
Parameters: none; all widths come from cpu_pkg (DATA_W=16, REG_AW=4, NREGS=16).
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed as follows.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-002 The upstream (fetch) port SHALL be:
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid & in_ready at clk edge.
- in_instr  in  16  instruction word.
REQ-003 The downstream (ALU) port SHALL be:
- out_valid  out  1  decoded operation present.
- out_ready  in  1  ALU accepts.
- out_op  out  3  alu_op_t.
- out_rd  out  4  destination register.
- out_a  out  16  operand A.
- out_b  out  16  operand B.
- out_imm8  out  8  raw immediate.
REQ-004 The writeback and status ports SHALL be:
- wb_en  in  1  writeback strobe.
- wb_addr  in  4  register to write.
- wb_data  in  16  write data.
- err_illegal  out  1  sticky flag.
- err_wb  out  1  sticky flag.
- issued_cnt  out  16  count of issued instructions.

Function
REQ-005 Instruction format SHALL be op=[15:12], rd=[11:8]; R-type adds rs=[7:4] and rt=[3:0]; I-type adds imm8=[7:0], with rd also serving as the source register.
REQ-006 Opcodes SHALL be ADD=0, SUB=1, AND=2 (R-type), and SLL=3, ADDI=4, LW=5 (I-type); 6..15 SHALL be illegal.
REQ-007 For R-type instructions, out_a=R[rs] and out_b=R[rt].
REQ-008 For I-type instructions, out_a=R[rd]; out_b SHALL be the sign-extended imm8 for ADDI and LW, and the zero-extended imm8 for SLL.
REQ-009 R0 SHALL read as 0; writes to R0 SHALL be ignored; R0 SHALL never be marked pending.
REQ-010 A 16-bit scoreboard SHALL hold one pending bit per register.
REQ-011 Issue SHALL stall while any source register or rd is pending, using the registered scoreboard value.
REQ-012 in_ready SHALL equal (!out_valid | out_ready) & !hazard, where hazard is evaluated on the current in_instr.
REQ-013 Latency SHALL be one cycle: an instruction accepted at edge N drives out_valid high after edge N.
REQ-014 Out_* signals SHALL be held stable while out_valid & !out_ready.
REQ-015 With out_ready held high and no hazards, the block SHALL sustain one instruction per cycle.
REQ-016 On issue, pending[rd] SHALL be set when rd!=0.
REQ-017 On wb_en, R[wb_addr] SHALL be written and pending[wb_addr] cleared at the same edge; register and scoreboard updates are visible from the next cycle, with no bypass.
REQ-018 If issue sets and writeback clears the same register in one cycle, set SHALL win.
REQ-019 wb_en to a register that is not pending SHALL still write (unless R0) and SHALL set err_wb.
REQ-020 An illegal opcode SHALL be accepted and dropped: no out_valid, no scoreboard change, err_illegal set.
REQ-021 issued_cnt SHALL increment on each in_valid & in_ready of a legal instruction, wrapping from 0xFFFF to 0x0000.
REQ-022 err_illegal and err_wb SHALL be sticky until reset.

Reset
REQ-023 rst_n low SHALL immediately force out_valid=0, all pending bits=0, all registers=0, err_*=0, issued_cnt=0, and out_op/out_rd/out_a/out_b/out_imm8=0.
REQ-024 While rst_n is low, in_ready SHALL be 0.
REQ-025 Reset asserted mid-handshake SHALL discard the held output; downstream SHALL see no transfer.
REQ-026 Deassertion SHALL take effect at the first clk edge after rst_n rises.

Structure
REQ-027 cpu_pkg SHALL hold the opcode enum, alu_op_t, instruction field positions, DATA_W, REG_AW and NREGS.
REQ-028 Register storage SHALL be a sub-module regfile with three combinational read ports, one synchronous write port, and R0 hardwired to zero.
REQ-029 The scoreboard, output register and counters SHALL reside in decode_stage.

Verification
REQ-030 Write R3=0x0005 via wb, then issue ADDI r3,0xFF (0x43FF) -> next cycle out_op=ADDI, out_a=0x0005, out_b=0xFFFF, pending[3]=1.
REQ-031 Issue SUB r1,r3,r3 right after the ADDI above with no wb -> in_ready=0 until the wb to r3; issue occurs the cycle after the wb edge with out_a=out_b=wb_data.
REQ-032 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> transfer, new instruction accepted in the same cycle.
REQ-033 Instruction 0x9000 -> no out_valid, err_illegal=1, issued_cnt unchanged.
REQ-034 Preload issued_cnt to 0xFFFF (one instruction after 65535 issues) -> the next issue reads 0x0000; wb_en to a non-pending r7 -> err_wb=1 and R7 written.
REQ-035 Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 with no clk edge, scoreboard cleared, R1..R15 read 0.
